// File: rtl/ir_receiver.sv
// ============================================================================
// Module      : ir_receiver
// Description : IrDA SIR pulse receiver. A rising edge on the synchronised
//               photodiode input marks the start bit. Each following bit
//               period is sampled over a window; a pulse in the window is a
//               0 and no pulse is a 1. Data arrives LSB first. The stop
//               window flags a framing error if it sees a pulse.
//               Optional feature macro: IR_RX_PARITY_EN (adds an even parity
//               bit between the data bits and the stop bit).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ir_receiver #(
    parameter int BIT_CLKS = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ir_rx,
    output logic [7:0] rx_8bitdata,
    output logic       wr_data,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_available
);

    // Last count of a full bit window, and last count of the gap between the
    // start edge and the first window (the first DATA cycle is offset 1).
    localparam logic [15:0] C_BIT_LAST = 16'(BIT_CLKS - 1);
    localparam logic [15:0] C_PRE_LAST = 16'(BIT_CLKS - BIT_CLKS / 4 - 2);

`ifdef IR_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_DONE   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_STOP   = 3'd3,
        S_DONE   = 3'd4
    } state_t;
`endif

    state_t      r_state;
    state_t      w_next;
    logic        r_sync1;
    logic        r_irs;
    logic        r_irs_d;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_cnt;
    logic        r_open;
    logic        r_seen;
    logic [7:0]  r_shift;
    logic [7:0]  r_data;
    logic        r_wr;
    logic        r_frame_err;
    logic        w_pulse;
    logic        w_close;
    logic        w_bit;

    assign w_pulse = r_irs & ~r_irs_d;
    assign w_close = r_open && (r_cnt == C_BIT_LAST);
    // Bit value of the window closing this cycle: any pulse seen means 0.
    assign w_bit   = ~(r_seen | w_pulse);

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_irs   <= 1'b0;
            r_irs_d <= 1'b0;
        end else begin
            r_sync1 <= ir_rx;
            r_irs   <= r_sync1;
            r_irs_d <= r_irs;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: frames advance only when a bit window closes.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_pulse) w_next = S_DATA;
            end
            S_DATA: begin
`ifdef IR_RX_PARITY_EN
                if (w_close && r_bit_cnt == 3'd7) w_next = S_PARITY;
`else
                if (w_close && r_bit_cnt == 3'd7) w_next = S_STOP;
`endif
            end
`ifdef IR_RX_PARITY_EN
            S_PARITY: begin
                if (w_close) w_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_close) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Window timing, bit collection and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt       <= 16'd0;
            r_bit_cnt   <= 3'd0;
            r_open      <= 1'b0;
            r_seen      <= 1'b0;
            r_shift     <= 8'h00;
            r_data      <= 8'h00;
            r_wr        <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pulse) begin
                        r_cnt     <= 16'd0;
                        r_bit_cnt <= 3'd0;
                        r_open    <= 1'b0;
                        r_seen    <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_open <= 1'b0;
                end
                default: begin
                    if (!r_open) begin
                        // Gap before the first window: pulses are ignored.
                        if (r_cnt == C_PRE_LAST) begin
                            r_cnt  <= 16'd0;
                            r_open <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 16'd1;
                        end
                    end else if (w_close) begin
                        r_cnt  <= 16'd0;
                        r_seen <= 1'b0;
                        if (r_state == S_DATA) begin
                            r_shift   <= {w_bit, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                        if (r_state == S_STOP) begin
                            r_data      <= r_shift;
                            r_frame_err <= ~w_bit;
                            r_wr        <= 1'b1;
                        end
                    end else begin
                        r_cnt  <= r_cnt + 16'd1;
                        r_seen <= r_seen | w_pulse;
                    end
                end
            endcase
        end
    end

`ifdef IR_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;

    // Capture the parity bit, then check even parity as the stop window closes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state == S_PARITY && w_close) r_par_bit <= w_bit;
            if (r_state == S_STOP && w_close) r_parity_err <= (^r_shift) ^ r_par_bit;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_8bitdata  = r_data;
    assign wr_data      = r_wr;
    assign frame_err    = r_frame_err;
    assign rx_available = (r_state == S_IDLE);

endmodule

`default_nettype wire

// File: doc/ir_receiver.md
IR_RECEIVER -- requirements
Module: ir_receiver

Interface
REQ-001 SHALL have parameter BIT_CLKS, default 5208, clock cycles per bit period (50 MHz / 9600 baud); legal range 16..65535.
REQ-002 SHALL have port clock  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ir_rx  input  1  IrDA SIR pulse from photodiode front end; active-high, asynchronous to clock.
REQ-005 SHALL have port rx_8bitdata  output  8  last received data byte.
REQ-006 SHALL have port wr_data  output  1  one-cycle strobe, byte valid; drives fifo_control write.
REQ-007 SHALL have port parity_err  output  1  parity error flag of last frame.
REQ-008 SHALL have port frame_err  output  1  stop-bit error flag of last frame.
REQ-009 SHALL have port rx_available  output  1  high while in IDLE, ready for a start pulse.

Function
REQ-010 SHALL synchronise ir_rx through two flip-flops; all decoding uses the synchronised signal (irs).
REQ-011 SHALL define pulse event = irs rising edge (irs high now, low previous cycle).
REQ-012 SHALL encode per IrDA SIR: pulse within a bit window = bit 0; no pulse = bit 1; data LSB first.
REQ-013 SHALL run states IDLE -> DATA -> PARITY (PARITY_EN only) -> STOP -> DONE -> IDLE.
REQ-014 SHALL, in IDLE, take a pulse event as the start bit, clear the 16-bit cycle counter and 3-bit bit counter, and enter DATA next cycle.
REQ-015 SHALL open bit window k (k=1 first data bit) at start-edge offset k*BIT_CLKS - BIT_CLKS/4 and close it at (k+1)*BIT_CLKS - BIT_CLKS/4; integer division.
REQ-016 SHALL treat one or more pulse events within a window as a single 0; no pulse = 1.
REQ-017 SHALL leave DATA after the 8th window closes, bit counter wrapping 7 -> 0.
REQ-018 SHALL treat the stop window (last window) as stop bit: pulse seen -> frame_err=1, else 0.
REQ-019 SHALL, in DONE (one cycle), load rx_8bitdata, parity_err, frame_err together and assert wr_data for that cycle only, then return to IDLE.
REQ-020 SHALL deliver the byte and strobe even when frame_err or parity_err is set.
REQ-021 SHALL give latency from stop-window close to wr_data = 1 cycle.
REQ-022 SHALL hold rx_8bitdata, parity_err, frame_err stable between wr_data strobes.
REQ-023 SHALL ignore pulse events outside IDLE that fall in no window; SHALL not accept a new start until IDLE.
REQ-024 SHALL drive rx_available=1 only in IDLE, combinationally from state.

Reset
REQ-025 SHALL, on reset low, force IDLE, counters 0, synchroniser flops 0, rx_8bitdata=8'h00, wr_data=0, parity_err=0, frame_err=0, rx_available=1.
REQ-026 SHALL abort any frame in progress on reset with no wr_data strobe; after release, the first pulse event is a start bit.

Configuration
REQ-027 SHALL use macro IR_RX_PARITY_EN: defined -> frame is start, 8 data, even parity, stop (stop window k=10); parity_err=1 when the XOR of data bits and parity bit is 1.
REQ-028 SHALL, without IR_RX_PARITY_EN, use frame start, 8 data, stop (stop window k=9); no PARITY state; parity_err constant 0.

Verification (BIT_CLKS=16, IR_RX_PARITY_EN defined unless noted)
REQ-029 SHALL check: frame 0x55, correct parity, no stop pulse -> one wr_data, rx_8bitdata=0x55, parity_err=0, frame_err=0, 1 cycle after stop-window close.
REQ-030 SHALL check: frame 0xA3 with wrong parity bit -> rx_8bitdata=0xA3, parity_err=1, frame_err=0.
REQ-031 SHALL check: frame 0x0F with pulse in stop window -> rx_8bitdata=0x0F, frame_err=1, wr_data still pulses once.
REQ-032 SHALL check: reset low mid-DATA of frame 0x81 -> no wr_data, outputs at reset values; next frame 0x3C received correctly.
REQ-033 SHALL check: back-to-back frames 0x00, 0xFF with next start at 11*BIT_CLKS -> two strobes, data 0x00 then 0xFF, no errors.
REQ-034 SHALL check, IR_RX_PARITY_EN undefined: frame 0x5A with no parity bit -> rx_8bitdata=0x5A, parity_err=0, rx_available high by 10*BIT_CLKS after start edge.
